as1802_io_ports: RTL and testbench

//  - Decodes AS1802 I/O cycles (N lines, MRD, TPB) into GPIO-facing output latches, input ports and an EF-flag interrupt source.
//  - Sits between the wrapped_as1802 core and the mprj_io pad bits; drives the pins the firmware test monitor reads (stage / error bits).

---
 rtl/as1802_io_pkg.sv | 25 ++
 rtl/as1802_io_sync.sv | 36 +++
 rtl/as1802_io_ports.sv | 193 +++++++++++++++++++
 tb/tb_as1802_io_ports.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/as1802_io_pkg.sv
// as1802_io_pkg
//   Shared definitions for the AS1802 I/O port block: N-line port numbers,
//   the I/O-cycle FSM state encoding and default port widths.
package as1802_io_pkg;

    localparam int OUT_W_DEF = 8;
    localparam int EF_W_DEF  = 4;

    // N[2:0] port numbers as seen on the core's N lines
    localparam logic [2:0] PORT_NONE   = 3'd0;
    localparam logic [2:0] PORT_OUT1   = 3'd1;  // OUT: gpio_out[7:0]
    localparam logic [2:0] PORT_OUT2   = 3'd2;  // OUT: gpio_out[15:8]
    localparam logic [2:0] PORT_OEB_LO = 3'd3;  // OUT: gpio_oeb[7:0]
    localparam logic [2:0] PORT_IN_LO  = 3'd4;  // INP: gpio_in[7:0]
    localparam logic [2:0] PORT_IN_HI  = 3'd5;  // INP: gpio_in[15:8]
    localparam logic [2:0] PORT_OEB_HI = 3'd6;  // OUT: gpio_oeb[15:8]
    localparam logic [2:0] PORT_MISC   = 3'd7;  // OUT: irq mask / INP: status

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        COMMIT  = 2'd2
    } io_state_t;

endpackage

// File: rtl/as1802_io_sync.sv
// as1802_io_sync
//   STAGES-deep flop chain synchroniser for a vector of asynchronous inputs.
//   Each bit is synchronised independently; no cross-bit coherence implied.
// Ports
//   i_clk  : clock
//   i_rst  : synchronous active-high reset (all stages cleared)
//   i_d    : raw asynchronous input vector
//   o_q    : synchronised output, STAGES cycles of latency
module as1802_io_sync
    import as1802_io_pkg::*;
#(
    parameter int WIDTH  = OUT_W_DEF,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= i_d;
            for (int s = 1; s < STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/as1802_io_ports.sv
// as1802_io_ports
//   Decodes AS1802 I/O machine cycles (N lines, MRD, TPB) into GPIO output
//   latches, direction registers, synchronised input ports and EF flags.
//   Optional EF-driven interrupt logic is built when AS1802_IO_IRQ_EN is
//   defined; otherwise pending/mask are constant 0 and cpu_int_n is tied 1.
// Ports
//   wb_clk_i       : single clock shared with the core
//   wb_rst_i       : synchronous active-high reset
//   cpu_n          : N[2:0] from the core, 0 = no I/O
//   cpu_mrd_n      : 0 = OUT (memory -> port), 1 = INP (port -> memory)
//   cpu_tpb        : timing pulse B, end of machine cycle
//   cpu_dout       : bus byte from memory during OUT
//   cpu_din        : byte returned to the core during INP
//   cpu_din_valid  : high while cpu_din holds an INP result
//   cpu_ef_n       : synchronised active-low EF flags
//   cpu_int_n      : active-low interrupt request
//   gpio_out       : port1 -> [OUT_W-1:0], port2 -> [2*OUT_W-1:OUT_W]
//   gpio_oeb       : active-low pad output enables (1 = input)
//   gpio_in        : raw asynchronous pad inputs
//   ef_in          : raw asynchronous active-high EF inputs
module as1802_io_ports
    import as1802_io_pkg::*;
#(
    parameter int OUT_W       = OUT_W_DEF,
    parameter int EF_W        = EF_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [2:0]         cpu_n,
    input  logic               cpu_mrd_n,
    input  logic               cpu_tpb,
    input  logic [7:0]         cpu_dout,
    output logic [7:0]         cpu_din,
    output logic               cpu_din_valid,
    output logic [EF_W-1:0]    cpu_ef_n,
    output logic               cpu_int_n,
    output logic [2*OUT_W-1:0] gpio_out,
    output logic [2*OUT_W-1:0] gpio_oeb,
    input  logic [2*OUT_W-1:0] gpio_in,
    input  logic [EF_W-1:0]    ef_in
);

    io_state_t          r_state, w_next;
    logic [2:0]         r_n;
    logic               r_out_cyc;
    logic [7:0]         r_din;
    logic               r_din_valid;
    logic [2*OUT_W-1:0] r_gpio_out;
    logic [2*OUT_W-1:0] r_gpio_oeb;

    logic [2*OUT_W-1:0] w_gpio_sync;
    logic [EF_W-1:0]    w_ef_sync;
    logic [EF_W-1:0]    w_pend;
    logic [7:0]         w_status;
    logic [7:0]         w_rd_data;
    logic               w_enter;
    logic               w_abort;
    logic               w_tpb_edge;
    logic               w_wr_en;

    as1802_io_sync #(.WIDTH(2*OUT_W), .STAGES(SYNC_STAGES)) u_sync_gpio (
        .i_clk (wb_clk_i),
        .i_rst (wb_rst_i),
        .i_d   (gpio_in),
        .o_q   (w_gpio_sync)
    );

    as1802_io_sync #(.WIDTH(EF_W), .STAGES(SYNC_STAGES)) u_sync_ef (
        .i_clk (wb_clk_i),
        .i_rst (wb_rst_i),
        .i_d   (ef_in),
        .o_q   (w_ef_sync)
    );

    // Next-state logic. Any change of N while in CAPTURE (including N->0)
    // without TPB aborts the cycle. COMMIT may go straight to CAPTURE so
    // back-to-back I/O cycles need no bubble.
    always_comb begin
        w_next     = r_state;
        w_abort    = 1'b0;
        w_tpb_edge = 1'b0;
        case (r_state)
            IDLE: begin
                if (cpu_n != PORT_NONE) w_next = CAPTURE;
            end
            CAPTURE: begin
                if (cpu_n != r_n) begin
                    w_next  = IDLE;
                    w_abort = 1'b1;
                end else if (cpu_tpb) begin
                    w_next     = COMMIT;
                    w_tpb_edge = 1'b1;
                end
            end
            COMMIT: begin
                w_next = (cpu_n != PORT_NONE) ? CAPTURE : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_enter = (w_next == CAPTURE) && (r_state != CAPTURE);
    // OUT data is taken on the TPB edge so the latch is visible in COMMIT.
    assign w_wr_en = w_tpb_edge && r_out_cyc;

    assign w_status = {4'(w_pend), 4'(w_ef_sync)};

    always_comb begin
        w_rd_data = 8'h00;
        case (r_n)
            PORT_IN_LO: w_rd_data = w_gpio_sync[OUT_W-1:0];
            PORT_IN_HI: w_rd_data = w_gpio_sync[2*OUT_W-1:OUT_W];
            PORT_MISC:  w_rd_data = w_status;
            default:    w_rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= IDLE;
            r_n         <= PORT_NONE;
            r_out_cyc   <= 1'b0;
            r_din       <= 8'h00;
            r_din_valid <= 1'b0;
            r_gpio_out  <= '0;
            r_gpio_oeb  <= '1;
        end else begin
            r_state <= w_next;
            if (w_enter) begin
                r_n       <= cpu_n;
                r_out_cyc <= ~cpu_mrd_n;
            end
            // INP result is loaded once, one cycle into CAPTURE, and held
            // until the TPB edge (or an abort) clears it.
            if (w_abort || w_tpb_edge) begin
                r_din       <= 8'h00;
                r_din_valid <= 1'b0;
            end else if (r_state == CAPTURE && !r_out_cyc && !r_din_valid) begin
                r_din       <= w_rd_data;
                r_din_valid <= 1'b1;
            end
            if (w_wr_en) begin
                case (r_n)
                    PORT_OUT1:   r_gpio_out[OUT_W-1:0]       <= cpu_dout;
                    PORT_OUT2:   r_gpio_out[2*OUT_W-1:OUT_W] <= cpu_dout;
                    PORT_OEB_LO: r_gpio_oeb[OUT_W-1:0]       <= cpu_dout;
                    PORT_OEB_HI: r_gpio_oeb[2*OUT_W-1:OUT_W] <= cpu_dout;
                    default: ;
                endcase
            end
        end
    end

`ifdef AS1802_IO_IRQ_EN
    logic [EF_W-1:0] r_mask;
    logic [EF_W-1:0] r_pend;
    logic [EF_W-1:0] r_ef_prev;
    logic [EF_W-1:0] w_w1c;
    logic [EF_W-1:0] w_rise;
    logic            w_wr_misc;

    assign w_wr_misc = w_wr_en && (r_n == PORT_MISC);
    assign w_w1c     = w_wr_misc ? cpu_dout[4 +: EF_W] : '0;
    assign w_rise    = w_ef_sync & ~r_ef_prev;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_mask    <= '0;
            r_pend    <= '0;
            r_ef_prev <= '0;
        end else begin
            r_ef_prev <= w_ef_sync;
            // OR-ing the rise after the clear makes a same-cycle set win.
            r_pend    <= (r_pend & ~w_w1c) | w_rise;
            if (w_wr_misc) r_mask <= cpu_dout[EF_W-1:0];
        end
    end

    assign w_pend    = r_pend;
    assign cpu_int_n = ~|(r_pend & r_mask);
`else
    assign w_pend    = '0;
    assign cpu_int_n = 1'b1;
`endif

    assign cpu_din       = r_din;
    assign cpu_din_valid = r_din_valid;
    assign cpu_ef_n      = ~w_ef_sync;
    assign gpio_out      = r_gpio_out;
    assign gpio_oeb      = r_gpio_oeb;

endmodule

// File: tb/tb_as1802_io_ports.sv
module tb_as1802_io_ports;

    localparam int OUT_W = 8;
    localparam int EF_W  = 4;
    localparam int SYNC  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        cpu_n;
    logic              cpu_mrd_n;
    logic              cpu_tpb;
    logic [7:0]        cpu_dout;
    logic [7:0]        cpu_din;
    logic              cpu_din_valid;
    logic [EF_W-1:0]   cpu_ef_n;
    logic              cpu_int_n;
    logic [15:0]       gpio_out;
    logic [15:0]       gpio_oeb;
    logic [15:0]       gpio_in;
    logic [EF_W-1:0]   ef_in;

    int errors = 0;
    int checks = 0;

    as1802_io_ports #(.OUT_W(OUT_W), .EF_W(EF_W), .SYNC_STAGES(SYNC)) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .cpu_n         (cpu_n),
        .cpu_mrd_n     (cpu_mrd_n),
        .cpu_tpb       (cpu_tpb),
        .cpu_dout      (cpu_dout),
        .cpu_din       (cpu_din),
        .cpu_din_valid (cpu_din_valid),
        .cpu_ef_n      (cpu_ef_n),
        .cpu_int_n     (cpu_int_n),
        .gpio_out      (gpio_out),
        .gpio_oeb      (gpio_oeb),
        .gpio_in       (gpio_in),
        .ef_in         (ef_in)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One full I/O machine cycle: entry, two CAPTURE cycles, TPB.
    // Returns cpu_din/cpu_din_valid as seen in the TPB cycle. Leaves
    // cpu_n=0 after the TPB edge without ticking, so the caller observes
    // COMMIT and may chain another cycle with no bubble.
    task automatic do_cycle(input logic [2:0] n, input logic is_out, input logic [7:0] data,
                            output logic [7:0] din_tpb, output logic vld_tpb);
        cpu_n     = n;
        cpu_mrd_n = ~is_out;
        cpu_dout  = data;
        tick(3);
        din_tpb = cpu_din;
        vld_tpb = cpu_din_valid;
        cpu_tpb = 1'b1;
        tick();
        cpu_tpb  = 1'b0;
        cpu_n    = 3'd0;
        cpu_dout = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        checks++; if (gpio_oeb !== 16'hFFFF) begin errors++; $display("FAIL reset_oeb: got %h expected ffff", gpio_oeb); end
        checks++; if (gpio_out !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h expected 0000", gpio_out); end
        checks++; if (cpu_int_n !== 1'b1) begin errors++; $display("FAIL reset_int_n: got %b expected 1", cpu_int_n); end
        checks++; if (cpu_din_valid !== 1'b0 || cpu_din !== 8'h00) begin errors++; $display("FAIL reset_din: got %b/%h expected 0/00", cpu_din_valid, cpu_din); end
        checks++; if (cpu_ef_n !== 4'hF) begin errors++; $display("FAIL reset_ef_n: got %h expected f", cpu_ef_n); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_out1();
        cpu_n = 3'd1; cpu_mrd_n = 1'b0; cpu_dout = 8'h5A;
        tick(3);
        checks++; if (gpio_out !== 16'h0000) begin errors++; $display("FAIL out1_before_tpb: got %h expected 0000", gpio_out); end
        cpu_tpb = 1'b1;
        tick();
        cpu_tpb = 1'b0; cpu_n = 3'd0;
        checks++; if (gpio_out !== 16'h005A) begin errors++; $display("FAIL out1_latch: got %h expected 005a", gpio_out); end
        tick();
    endtask

    task automatic test_oeb();
        logic [7:0] d; logic v;
        do_cycle(3'd3, 1'b1, 8'h00, d, v); tick();
        checks++; if (gpio_oeb !== 16'hFF00) begin errors++; $display("FAIL oeb_lo: got %h expected ff00", gpio_oeb); end
        do_cycle(3'd1, 1'b1, 8'h9F, d, v); tick();
        checks++; if (gpio_out !== 16'h009F) begin errors++; $display("FAIL out1_9f: got %h expected 009f", gpio_out); end
        do_cycle(3'd6, 1'b1, 8'h0F, d, v); tick();
        checks++; if (gpio_oeb !== 16'h0F00) begin errors++; $display("FAIL oeb_hi: got %h expected 0f00", gpio_oeb); end
        do_cycle(3'd2, 1'b1, 8'hA5, d, v); tick();
        checks++; if (gpio_out !== 16'hA59F) begin errors++; $display("FAIL out2: got %h expected a59f", gpio_out); end
    endtask

    task automatic test_inp();
        logic [7:0] d; logic v;
        logic [7:0] exp_status;
        gpio_in = 16'hC33C;
        tick(SYNC + 1);
        do_cycle(3'd5, 1'b0, 8'h00, d, v);
        checks++; if (v !== 1'b1 || d !== 8'hC3) begin errors++; $display("FAIL inp_hi: got %b/%h expected 1/c3", v, d); end
        checks++; if (cpu_din_valid !== 1'b0) begin errors++; $display("FAIL inp_clear: got %b expected 0", cpu_din_valid); end
        tick();
        do_cycle(3'd4, 1'b0, 8'h00, d, v); tick();
        checks++; if (v !== 1'b1 || d !== 8'h3C) begin errors++; $display("FAIL inp_lo: got %b/%h expected 1/3c", v, d); end
        do_cycle(3'd1, 1'b0, 8'h00, d, v); tick();
        checks++; if (v !== 1'b1 || d !== 8'h00) begin errors++; $display("FAIL inp_unused: got %b/%h expected 1/00", v, d); end
        ef_in = 4'b0101;
        tick(SYNC + 1);
        checks++; if (cpu_ef_n !== 4'b1010) begin errors++; $display("FAIL ef_n: got %b expected 1010", cpu_ef_n); end
`ifdef AS1802_IO_IRQ_EN
        exp_status = 8'h55;
`else
        exp_status = 8'h05;
`endif
        do_cycle(3'd7, 1'b0, 8'h00, d, v); tick();
        checks++; if (v !== 1'b1 || d !== exp_status) begin errors++; $display("FAIL inp_status: got %b/%h expected 1/%h", v, d, exp_status); end
        ef_in = 4'b0000;
        tick(SYNC + 1);
    endtask

    task automatic test_out_unused();
        logic [7:0] d; logic v;
        do_cycle(3'd4, 1'b1, 8'hFF, d, v); tick();
        do_cycle(3'd5, 1'b1, 8'hFF, d, v); tick();
        checks++; if (gpio_out !== 16'hA59F || gpio_oeb !== 16'h0F00) begin errors++; $display("FAIL out_unused: got %h/%h expected a59f/0f00", gpio_out, gpio_oeb); end
    endtask

    task automatic test_abort();
        cpu_n = 3'd1; cpu_mrd_n = 1'b0; cpu_dout = 8'hFF;
        tick(2);
        cpu_n = 3'd0;
        tick();
        cpu_tpb = 1'b1;
        tick();
        cpu_tpb = 1'b0; cpu_dout = 8'h00;
        tick();
        checks++; if (gpio_out !== 16'hA59F) begin errors++; $display("FAIL abort: got %h expected a59f", gpio_out); end
        // Abort of an INP cycle must drop valid
        cpu_n = 3'd4; cpu_mrd_n = 1'b1;
        tick(2);
        cpu_n = 3'd0;
        tick();
        checks++; if (cpu_din_valid !== 1'b0) begin errors++; $display("FAIL abort_inp_valid: got %b expected 0", cpu_din_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d; logic v;
        do_cycle(3'd1, 1'b1, 8'h11, d, v);
        checks++; if (gpio_out !== 16'hA511) begin errors++; $display("FAIL b2b_first: got %h expected a511", gpio_out); end
        do_cycle(3'd2, 1'b1, 8'h22, d, v);
        checks++; if (gpio_out !== 16'h2211) begin errors++; $display("FAIL b2b_second: got %h expected 2211", gpio_out); end
        tick();
    endtask

    task automatic test_irq();
        logic [7:0] d; logic v;
`ifdef AS1802_IO_IRQ_EN
        do_cycle(3'd7, 1'b1, 8'hF0, d, v); tick();
        do_cycle(3'd7, 1'b1, 8'h01, d, v); tick();
        checks++; if (cpu_int_n !== 1'b1) begin errors++; $display("FAIL irq_idle: got %b expected 1", cpu_int_n); end
        ef_in = 4'b0001;
        tick(SYNC);
        checks++; if (cpu_int_n !== 1'b1) begin errors++; $display("FAIL irq_early: got %b expected 1", cpu_int_n); end
        tick();
        checks++; if (cpu_int_n !== 1'b0) begin errors++; $display("FAIL irq_assert: got %b expected 0", cpu_int_n); end
        do_cycle(3'd7, 1'b1, 8'h11, d, v);
        checks++; if (cpu_int_n !== 1'b1) begin errors++; $display("FAIL irq_w1c: got %b expected 1", cpu_int_n); end
        tick();
        do_cycle(3'd7, 1'b0, 8'h00, d, v); tick();
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL irq_status: got %h expected 01", d); end
`else
        do_cycle(3'd7, 1'b1, 8'h01, d, v); tick();
        ef_in = 4'b0001;
        tick(SYNC + 2);
        checks++; if (cpu_int_n !== 1'b1) begin errors++; $display("FAIL irq_disabled: got %b expected 1", cpu_int_n); end
        do_cycle(3'd7, 1'b0, 8'h00, d, v); tick();
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL irq_status: got %h expected 01", d); end
`endif
        ef_in = 4'b0000;
        tick(SYNC + 1);
    endtask

    task automatic test_reset_mid();
        cpu_n = 3'd2; cpu_mrd_n = 1'b0; cpu_dout = 8'h77;
        tick(2);
        rst = 1'b1; cpu_tpb = 1'b1;
        tick();
        checks++; if (gpio_out !== 16'h0000 || gpio_oeb !== 16'hFFFF) begin errors++; $display("FAIL reset_mid: got %h/%h expected 0000/ffff", gpio_out, gpio_oeb); end
        rst = 1'b0; cpu_tpb = 1'b0; cpu_n = 3'd0; cpu_dout = 8'h00;
        tick(2);
        checks++; if (gpio_out !== 16'h0000) begin errors++; $display("FAIL reset_mid_lost: got %h expected 0000", gpio_out); end
    endtask

    initial begin
        rst = 1'b1; cpu_n = 3'd0; cpu_mrd_n = 1'b1; cpu_tpb = 1'b0;
        cpu_dout = 8'h00; gpio_in = 16'h0000; ef_in = '0;
        test_reset();
        test_out1();
        test_oeb();
        test_inp();
        test_out_unused();
        test_abort();
        test_back_to_back();
        test_irq();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
